// File: rtl/ecc_177_err_monitor_pkg.sv
// Shared definitions for the ECC error monitor: default widths, error-type
// encoding, capture FSM states and the event classification helper.
package ecc_177_err_monitor_pkg;

    localparam int DEF_DATA_WIDTH = 177;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 8;

    // Bit positions inside the {fault,dbit,sbit} flag vectors
    localparam int FLAG_SBIT  = 0;
    localparam int FLAG_DBIT  = 1;
    localparam int FLAG_FAULT = 2;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_SBIT  = 2'b01,
        ERR_DBIT  = 2'b10,
        ERR_FAULT = 2'b11
    } err_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOGGED = 2'b01,
        ST_OVF    = 2'b10
    } cap_state_e;

    // Highest-severity type present in a qualified {fault,dbit,sbit} vector
    function automatic err_type_e classify(input logic [2:0] flags);
        err_type_e t;
        t = ERR_NONE;
        if (flags[FLAG_FAULT])     t = ERR_FAULT;
        else if (flags[FLAG_DBIT]) t = ERR_DBIT;
        else if (flags[FLAG_SBIT]) t = ERR_SBIT;
        return t;
    endfunction

endpackage

// File: rtl/ecc_sat_cnt.sv
// Saturating event counter; a clear in the same cycle as an increment
// restarts the count at one so that cycle's event is not lost.
module ecc_sat_cnt #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? CNT_WIDTH'(1) : '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ecc_177_err_monitor.sv
// Monitors the ECC checker result stream: registers the data path, counts
// error events, captures the first error and raises a maskable interrupt.
module ecc_177_err_monitor
    import ecc_177_err_monitor_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_vld,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  sbit_err,
    input  logic                  dbit_err,
    input  logic                  ecc_fault,
    input  logic                  err_clr,
    input  logic [2:0]            irq_en,
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_poison,
    output logic [CNT_WIDTH-1:0]  sbit_cnt,
    output logic [CNT_WIDTH-1:0]  dbit_cnt,
    output logic [CNT_WIDTH-1:0]  fault_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [1:0]            first_err_type,
    output logic                  err_ovf,
    output logic [2:0]            err_sticky,
    output logic                  irq
);

    logic [2:0] ev_flags;
    logic       ev_any;
    err_type_e  ev_type;
    cap_state_e state;

    // Checker status is only meaningful alongside rd_vld
    assign ev_flags = {ecc_fault, dbit_err, sbit_err} & {3{rd_vld}};
    assign ev_any   = |ev_flags;
    assign ev_type  = classify(ev_flags);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld    <= 1'b0;
            data_out   <= '0;
            out_poison <= 1'b0;
        end else begin
            out_vld    <= rd_vld;
            out_poison <= ev_flags[FLAG_DBIT] | ev_flags[FLAG_FAULT];
            if (rd_vld) begin
                data_out <= data_in;
            end
        end
    end

    ecc_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_sbit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ev_flags[FLAG_SBIT]),
        .clr   (err_clr),
        .cnt   (sbit_cnt)
    );

    ecc_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_dbit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ev_flags[FLAG_DBIT]),
        .clr   (err_clr),
        .cnt   (dbit_cnt)
    );

    ecc_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_fault_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ev_flags[FLAG_FAULT]),
        .clr   (err_clr),
        .cnt   (fault_cnt)
    );

    // irq looks at the already-registered sticky bits, hence one extra cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 3'b000;
            irq        <= 1'b0;
        end else begin
            irq        <= |(err_sticky & irq_en);
            err_sticky <= err_clr ? ev_flags : (err_sticky | ev_flags);
        end
    end

    // Capture FSM: a clear takes effect first, then the same-cycle event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            first_err_addr <= '0;
            first_err_type <= ERR_NONE;
            err_ovf        <= 1'b0;
        end else if (err_clr) begin
            err_ovf <= 1'b0;
            if (ev_any) begin
                state          <= ST_LOGGED;
                first_err_addr <= rd_addr;
                first_err_type <= ev_type;
            end else begin
                state          <= ST_IDLE;
                first_err_addr <= '0;
                first_err_type <= ERR_NONE;
            end
        end else if (ev_any) begin
            case (state)
                ST_IDLE: begin
                    state          <= ST_LOGGED;
                    first_err_addr <= rd_addr;
                    first_err_type <= ev_type;
                end
                ST_LOGGED: begin
                    state   <= ST_OVF;
                    err_ovf <= 1'b1;
                end
                ST_OVF: begin
                    err_ovf <= 1'b1;
                end
                default: begin
                    state          <= ST_IDLE;
                    first_err_addr <= '0;
                    first_err_type <= ERR_NONE;
                    err_ovf        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ecc_177_err_monitor.md
ECC_177_ERR_MONITOR -- requirements
Module: ecc_177_err_monitor

Interface
REQ-001 Params SHALL be: DATA_WIDTH, 177, protected data width; ADDR_WIDTH, 8, read-address width; CNT_WIDTH, 8, error-counter width.
REQ-002 clk  input  1  single clock; all state rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rd_vld  input  1  qualifies current-cycle checker outputs (one read result).
REQ-005 rd_addr  input  ADDR_WIDTH  address of the word being checked.
REQ-006 data_in  input  DATA_WIDTH  corrected data from the upstream ECC fault-detect checker.
REQ-007 sbit_err / dbit_err / ecc_fault  input  1 each  checker status, meaningful only with rd_vld.
REQ-008 err_clr  input  1  single-cycle pulse; clears counters, sticky flags, capture state.
REQ-009 irq_en  input  3  interrupt enable {fault,dbit,sbit}.
REQ-010 out_vld  output  1  registered rd_vld.
REQ-011 data_out  output  DATA_WIDTH  registered data_in.
REQ-012 out_poison  output  1  registered (dbit_err|ecc_fault)&rd_vld.
REQ-013 sbit_cnt / dbit_cnt / fault_cnt  output  CNT_WIDTH each  saturating event counts.
REQ-014 first_err_addr  output  ADDR_WIDTH; first_err_type  output  2  (00 none, 01 sbit, 10 dbit, 11 fault).
REQ-015 err_ovf  output  1  set when an error arrives while a first error is already captured.
REQ-016 err_sticky  output  3  {fault,dbit,sbit} sticky flags.
REQ-017 irq  output  1  registered |(err_sticky & irq_en).

Function
REQ-018 Data path SHALL be one register stage: out_vld/data_out/out_poison valid exactly 1 cycle after rd_vld; data_out holds when rd_vld=0.
REQ-019 An event SHALL be rd_vld=1 with any of sbit_err/dbit_err/ecc_fault; inputs ignored when rd_vld=0.
REQ-020 Each counter SHALL increment by 1 per qualifying cycle of its own flag (independently; multiple flags in one cycle increment each), visible next cycle, saturating at 2^CNT_WIDTH-1 without wrap.
REQ-021 Event type priority for capture SHALL be fault > dbit > sbit.
REQ-022 Capture FSM states SHALL be IDLE, LOGGED, OVF: IDLE--event-->LOGGED (latch rd_addr, type); LOGGED--event-->OVF (err_ovf=1, capture unchanged); OVF--event-->OVF; any state--err_clr-->IDLE.
REQ-023 err_clr with simultaneous event SHALL clear first then apply the event: counters=the event's increments (1), sticky=event flags, FSM=LOGGED with new address/type.
REQ-024 err_sticky bits SHALL set on their event and clear only via err_clr/reset.
REQ-025 irq SHALL follow sticky/irq_en with 1-cycle register latency; irq_en change alone affects irq next cycle.
REQ-026 first_err_addr/type SHALL read 0/00 in IDLE.

Reset
REQ-027 On rst_n low all outputs SHALL be 0 asynchronously, FSM=IDLE; reset mid-stream discards the in-flight pipeline word.
REQ-028 First edge after rst_n rises SHALL behave as normal operation (no extra lock-out).

Structure
REQ-029 Shared package SHALL hold default parameters, err_type encoding (NONE/SBIT/DBIT/FAULT) and FSM state encoding.
REQ-030 One sub-module ecc_sat_cnt (CNT_WIDTH, inc, clr, saturating) SHALL be instantiated three times.

Verification
REQ-031 rd_vld=1, sbit_err=1, rd_addr=0x12 -> next cycle sbit_cnt=1, first_err_type=01, first_err_addr=0x12, err_sticky=001; with irq_en=001 irq=1 one cycle later.
REQ-032 Two events (dbit @0x05, then sbit+fault @0x07) -> type=10, addr=0x05, err_ovf=1, dbit_cnt=1, sbit_cnt=1, fault_cnt=1, state OVF.
REQ-033 300 sbit events with CNT_WIDTH=8 -> sbit_cnt=255 held, no wrap.
REQ-034 err_clr with dbit event @0x33 same cycle -> dbit_cnt=1, others 0, type=10, addr=0x33, err_ovf=0.
REQ-035 Flags asserted with rd_vld=0 -> no counter/sticky/FSM change; out_vld=0.
REQ-036 rst_n low mid-burst -> all outputs 0 immediately, irq=0; resume counts from 0.
